alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one combinational 8-bit ALU (alu: A, B, ALU_Sel -> 9-bit ALU_Result) between N_REQ requesters.
//  Round-robin arbitration; valid/ready request handshake; registered operands; response channel with backpressure.
//  Sits between the requesting control units and the alu instance; the only driver of the ALU inputs.
// PARAMETERS
//  N_REQ   2  number of requesters (>=2)
//  DATA_W  8  operand width; result width is DATA_W+1 (carry/borrow bit)
//  OP_W    4  opcode width, passed unchanged to ALU_Sel
//  ID_W    1  width of rsp_id, must satisfy 2**ID_W >= N_REQ
// PORTS
//  clk         in   1               rising-edge clock
//  rst         in   1               synchronous, active-high reset
//  req_valid   in   N_REQ           per-requester request valid
//  req_ready   out  N_REQ           one-hot accept; at most one bit high per cycle
//  req_a       in   N_REQ*DATA_W    packed operand A, requester i at [i*DATA_W +: DATA_W]
//  req_b       in   N_REQ*DATA_W    packed operand B, same packing
//  req_op      in   N_REQ*OP_W      packed opcode, same packing
//  rsp_valid   out  1               result valid
//  rsp_ready   in   1               consumer accepts result
//  rsp_result  out  DATA_W+1        ALU result
//  rsp_id      out  ID_W            index of the requester that owns rsp_result
//  busy        out  1               high whenever state != IDLE
// BEHAVIOUR
//  FSM: IDLE -> EXEC -> RESP -> IDLE.
//  - IDLE: if any req_valid, grant g is the first valid index at or after rr_ptr, modulo N_REQ.
//    - req_ready[g]=1 combinationally in this cycle; transfer occurs when req_valid[g]&req_ready[g].
//    - At the clock edge: latch a_q, b_q, op_q and id_q=g; go to EXEC.
//    - No valid requests: stay in IDLE with req_ready=0.
//  - EXEC: the alu instance is driven from a_q, b_q and op_q only, never from the raw req_* buses.
//    At the edge, res_q <= ALU_Result; go to RESP.
//  - RESP: rsp_valid=1, rsp_result=res_q, rsp_id=id_q.
//    - When rsp_ready: go to IDLE and set rr_ptr <= (id_q+1) mod N_REQ.
//    - Otherwise hold all rsp_* outputs stable.
//  req_ready is 0 in EXEC and RESP. req_ready depends only on state, rr_ptr and req_valid, never on rsp_ready.
//  Latency: accept edge T -> rsp_valid high from T+2. Minimum 3 cycles per operation (no overlap).
//  Arithmetic: result width DATA_W+1; the carry/borrow bit comes from the ALU unmodified.
//    The arbiter does not decode opcodes; unsupported opcodes yield whatever the ALU returns.
//  Simultaneous requests: exactly one is granted. Others see req_ready=0 and must hold valid and data.
//    Every continuously-valid requester is served within N_REQ operations (no starvation).
//  Request withdrawn (valid dropped) in the same cycle as ready: no transfer, stay in IDLE.
//  Reset: state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_result=0, rsp_id=0, busy=0, a_q/b_q/op_q/res_q/id_q=0.
//  rst in EXEC or RESP: the in-flight operation is dropped with no response; rst has priority over every transition.
//  N_REQ not a power of two: rr_ptr wraps from N_REQ-1 to 0.
// STRUCTURE
//  Package alu_pkg:
//    - opcode constants (ALU_ADD=4'b0000 etc.)
//    - FSM state encoding (IDLE, EXEC, RESP)
//    - DATA_W/OP_W defaults
//  Sub-module rr_arbiter(clk, rst, req, ptr -> grant one-hot, grant_idx): pure round-robin pick, reused elsewhere.
//  Top holds the FSM, operand and result registers, rr_ptr and one alu instance.
// TESTING
//  1. req0: A=240, B=15, op=ADD; rsp_ready=1
//     -> req_ready[0] high one cycle; rsp_valid at T+2; rsp_result=255; rsp_id=0.
//  2. req1: A=255, B=255, op=ADD -> rsp_result=9'h1FE (510), carry bit set, rsp_id=1.
//  3. After reset, req0 and req1 held valid with distinct operands
//     -> grants in order 0,1,0,1; each rsp_id matches its operands; req_ready never has two bits high.
//  4. rsp_ready held low 5 cycles in RESP -> rsp_valid, rsp_result and rsp_id stable; req_ready=0; no new accept.
//  5. rst pulsed during EXEC (A=10, B=20) -> no response; all outputs return to reset values next cycle;
//     after rst drops, rr_ptr=0 and the still-valid request is re-accepted.
//  6. req_valid[1] held while req0 is served; req1 operands changed while ready=0
//     -> value captured is the one present at its own accept edge.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants for the ALU arbiter slice: opcodes, FSM encoding, widths.
// No logic, no latency.
// No flow control.
package alu_pkg;

    localparam int ALU_DATA_W = 8;
    localparam int ALU_OP_W   = 4;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_AND = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_NOT = 4'b0101;
    localparam logic [3:0] ALU_SHL = 4'b0110;
    localparam logic [3:0] ALU_SHR = 4'b0111;
    localparam logic [3:0] ALU_INC = 4'b1000;
    localparam logic [3:0] ALU_DEC = 4'b1001;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

endpackage

// File: rtl/alu.sv
// Combinational ALU; the result carries one extra carry/borrow bit.
// Zero latency.
// No flow control; undefined opcodes return zero.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W
) (
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [OP_W-1:0]   ALU_Sel,
    output logic [DATA_W:0]   ALU_Result
);

    logic [DATA_W:0] a_x;
    logic [DATA_W:0] b_x;

    assign a_x = {1'b0, A};
    assign b_x = {1'b0, B};

    always_comb begin
        ALU_Result = '0;
        case (ALU_Sel)
            OP_W'(ALU_ADD): ALU_Result = a_x + b_x;
            OP_W'(ALU_SUB): ALU_Result = a_x - b_x;
            OP_W'(ALU_AND): ALU_Result = {1'b0, A & B};
            OP_W'(ALU_OR):  ALU_Result = {1'b0, A | B};
            OP_W'(ALU_XOR): ALU_Result = {1'b0, A ^ B};
            OP_W'(ALU_NOT): ALU_Result = {1'b0, ~A};
            OP_W'(ALU_SHL): ALU_Result = {A, 1'b0};
            // shifted-out LSB lands in the carry position
            OP_W'(ALU_SHR): ALU_Result = {A[0], 1'b0, A[DATA_W-1:1]};
            OP_W'(ALU_INC): ALU_Result = a_x + (DATA_W+1)'(1);
            OP_W'(ALU_DEC): ALU_Result = a_x - (DATA_W+1)'(1);
            default:        ALU_Result = '0;
        endcase
    end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin pick: first asserted request at or after ptr, wrapping at N_REQ.
// Zero latency; pointer ownership stays with the caller.
// No flow control; grant is zero when no request is asserted.
module rr_arbiter #(
    parameter int N_REQ = 2,
    parameter int ID_W  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx
);

    int   idx;
    logic found;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(ptr) + k) % N_REQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = ID_W'(idx);
            end
        end
    end

    a_grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
    a_grant_subset: assert property (@(posedge clk) disable iff (rst) (grant & ~req) == '0);
    a_grant_live:   assert property (@(posedge clk) disable iff (rst) (req != '0) |-> (grant != '0));

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters with round-robin arbitration.
// Accept edge T -> rsp_valid from T+2; one operation in flight, >=3 cycles each.
// req_ready only in IDLE; the response is held stable until rsp_ready.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int DATA_W = ALU_DATA_W,
    parameter int OP_W   = ALU_OP_W,
    parameter int ID_W   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_a,
    input  logic [N_REQ*DATA_W-1:0] req_b,
    input  logic [N_REQ*OP_W-1:0]   req_op,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_W:0]         rsp_result,
    output logic [ID_W-1:0]         rsp_id,
    output logic                    busy
);

    logic [1:0]        state;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   id_q;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [OP_W-1:0]   op_q;
    logic [DATA_W:0]   res_q;
    logic [DATA_W:0]   alu_result;

    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              accept;
    logic              rsp_done;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // ALU sees only the registered operands, never the live request buses
    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .A          (a_q),
        .B          (b_q),
        .ALU_Sel    (op_q),
        .ALU_Result (alu_result)
    );

    assign req_ready  = (state == IDLE) ? grant : '0;
    assign accept     = (state == IDLE) && ((req_valid & req_ready) != '0);
    assign rsp_done   = (state == RESP) && rsp_ready;

    assign rsp_valid  = (state == RESP);
    assign rsp_result = res_q;
    assign rsp_id     = id_q;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            rr_ptr <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q   <= req_a[grant_idx*DATA_W +: DATA_W];
                        b_q   <= req_b[grant_idx*DATA_W +: DATA_W];
                        op_q  <= req_op[grant_idx*OP_W +: OP_W];
                        id_q  <= grant_idx;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    res_q <= alu_result;
                    state <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        // pointer moves past the owner so N_REQ need not be a power of two
                        rr_ptr <= (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter against a transaction-level model.
module tb_alu_arbiter;
    import alu_pkg::*;

    localparam int N  = 3;
    localparam int DW = 8;
    localparam int OW = 4;
    localparam int IW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a;
    logic [N*DW-1:0] req_b;
    logic [N*OW-1:0] req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [DW:0]     rsp_result;
    logic [IW-1:0]   rsp_id;
    logic            busy;

    alu_arbiter #(.N_REQ(N), .DATA_W(DW), .OP_W(OW), .ID_W(IW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_id     (rsp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // transaction model: one op in flight, m_k counts edges since its accept
    int m_inflight = 0;
    int m_k        = 0;
    int m_ptr      = 0;
    int m_id       = 0;
    int m_res      = 0;
    int obs_res    = -1;
    int obs_id     = -1;
    int g_obs      = -1;
    int last_acc   = -1;
    int s_res, s_id;
    int grants[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int alu_ref(input int a, input int b, input int op);
        case (op)
            ALU_ADD: return a + b;
            ALU_SUB: return (a - b) & 511;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_XOR: return a ^ b;
            ALU_NOT: return (~a) & 255;
            ALU_SHL: return a * 2;
            ALU_SHR: return (a / 2) + (a % 2) * 256;
            ALU_INC: return a + 1;
            ALU_DEC: return (a - 1) & 511;
            default: return 0;
        endcase
    endfunction

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic set_req(input int i, input logic v, input int a, input int b, input int op);
        req_valid[i]        = v;
        req_a[i*DW +: DW]   = DW'(a);
        req_b[i*DW +: DW]   = DW'(b);
        req_op[i*OW +: OW]  = OW'(op);
    endtask

    task automatic step();
        int g;
        int exp_rdy;
        @(negedge clk);
        g       = pick();
        exp_rdy = (m_inflight == 0 && g >= 0) ? (1 << g) : 0;
        check("req_ready", 32'(req_ready), exp_rdy);
        check("rdy_onehot", 32'($onehot0(req_ready)), 1);
        check("busy", 32'(busy), m_inflight);
        check("rsp_valid", 32'(rsp_valid), (m_inflight != 0 && m_k >= 2) ? 1 : 0);
        if (m_inflight != 0 && m_k >= 2) begin
            check("rsp_result", 32'(rsp_result), m_res);
            check("rsp_id", 32'(rsp_id), m_id);
        end
        s_res = int'(rsp_result);
        s_id  = int'(rsp_id);
        g_obs = ((req_valid & req_ready) != '0) ? $clog2(req_valid & req_ready) : -1;
        @(posedge clk);
        last_acc = -1;
        if (!rst && g_obs >= 0) begin
            grants.push_back(g_obs);
            last_acc = g_obs;
        end
        if (rst) begin
            m_inflight = 0;
            m_ptr      = 0;
        end else if (m_inflight != 0) begin
            if (m_k >= 2 && rsp_ready) begin
                m_inflight = 0;
                m_ptr      = (m_id + 1) % N;
                obs_res    = s_res;
                obs_id     = s_id;
            end else begin
                m_k++;
            end
        end else if (g >= 0) begin
            m_id       = g;
            m_res      = alu_ref(int'(req_a[g*DW +: DW]), int'(req_b[g*DW +: DW]), int'(req_op[g*OW +: OW]));
            m_inflight = 1;
            m_k        = 1;
        end
        #1;
    endtask

    task automatic wait_done(input int budget);
        for (int n = 0; n < budget && m_inflight != 0; n++) step();
        check("done_timeout", m_inflight, 0);
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_result", 32'(rsp_result), 0);
        check("rst_id", 32'(rsp_id), 0);
        check("rst_busy", 32'(busy), 0);
        step();
        rst = 1'b0;

        // 1: plain add
        set_req(0, 1'b1, 240, 15, ALU_ADD);
        step();
        req_valid[0] = 1'b0;
        wait_done(20);
        check("t1_res", obs_res, 255);
        check("t1_id", obs_id, 0);

        // 2: carry out
        set_req(1, 1'b1, 255, 255, ALU_ADD);
        step();
        req_valid[1] = 1'b0;
        wait_done(20);
        check("t2_res", obs_res, 510);
        check("t2_id", obs_id, 1);

        // 3: alternating grants from reset
        rst = 1'b1;
        step();
        rst = 1'b0;
        grants.delete();
        set_req(0, 1'b1, 1, 2, ALU_ADD);
        set_req(1, 1'b1, 5, 6, ALU_SUB);
        for (int n = 0; n < 60 && grants.size() < 4; n++) step();
        check("t3_count", 32'(grants.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) check("t3_order", grants[i], i % 2);
        end
        req_valid = '0;
        wait_done(20);

        // 4: response backpressure
        set_req(0, 1'b1, 3, 4, ALU_XOR);
        rsp_ready = 1'b0;
        step();
        req_valid[0] = 1'b0;
        set_req(2, 1'b1, 9, 1, ALU_SUB);
        step();
        for (int n = 0; n < 5; n++) begin
            step();
            check("t4_hold_valid", 32'(rsp_valid), 1);
            check("t4_hold_res", 32'(rsp_result), 7);
            check("t4_hold_id", 32'(rsp_id), 0);
        end
        rsp_ready = 1'b1;
        wait_done(20);
        check("t4_res", obs_res, 7);
        step();
        req_valid[2] = 1'b0;
        wait_done(20);
        check("t4_next", obs_res, 8);

        // 5: reset during EXEC
        rst = 1'b1;
        step();
        rst = 1'b0;
        set_req(0, 1'b1, 10, 20, ALU_ADD);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_valid", 32'(rsp_valid), 0);
        check("t5_busy", 32'(busy), 0);
        check("t5_result", 32'(rsp_result), 0);
        check("t5_id", 32'(rsp_id), 0);
        step();
        check("t5_reaccept", last_acc, 0);
        req_valid[0] = 1'b0;
        wait_done(20);
        check("t5_res", obs_res, 30);

        // 6: waiting requester changes operands before its own accept
        set_req(2, 1'b1, 100, 1, ALU_SUB);
        step();
        req_valid[2] = 1'b0;
        wait_done(20);
        check("t6_pre", obs_res, 99);
        set_req(0, 1'b1, 9, 12, ALU_AND);
        set_req(1, 1'b1, 1, 1, ALU_ADD);
        step();
        check("t6_first", last_acc, 0);
        req_valid[0] = 1'b0;
        set_req(1, 1'b1, 50, 60, ALU_OR);
        step();
        set_req(1, 1'b1, 7, 3, ALU_ADD);
        wait_done(20);
        check("t6_r0", obs_res, 8);
        step();
        check("t6_second", last_acc, 1);
        set_req(1, 1'b0, 200, 200, ALU_ADD);
        wait_done(20);
        check("t6_res", obs_res, 10);
        check("t6_id", obs_id, 1);

        // randomized traffic
        for (int it = 0; it < 4000; it++) begin
            rsp_ready = ($urandom_range(0, 9) < 6);
            rst       = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < N; i++) begin
                if (last_acc == i) begin
                    if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
                    else set_req(i, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));
                end else if (!req_valid[i]) begin
                    if ($urandom_range(0, 9) < 4)
                        set_req(i, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));
                end else begin
                    if ($urandom_range(0, 99) < 5)
                        set_req(i, 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 15));
                    else if ($urandom_range(0, 99) < 3)
                        req_valid[i] = 1'b0;
                end
            end
            step();
        end
        rst       = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        wait_done(20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
